// File: rtl/dcache_sram_nway.sv
// N-way set-associative dcache tag/data storage with combinational lookup,
// true-LRU replacement and a sequential dirty-line flush engine.
module dcache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 23,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [TAG_W+1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic [TAG_W+1:0]  tag_o,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o,
  output logic [$clog2(WAYS)-1:0] hit_way_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              flush_valid_o,
  input  logic              flush_ready_i,
  output logic [TAG_W-1:0]  flush_tag_o,
  output logic [IDX_W-1:0]  flush_idx_o,
  output logic [DATA_W-1:0] flush_data_o,
  output logic              flush_done_o
);

  localparam int WAY_W = $clog2(WAYS);
  localparam int ENT_W = TAG_W + 2;
  localparam int PTR_W = IDX_W + WAY_W;
  localparam int VLD_B = TAG_W + 1;
  localparam int DRT_B = TAG_W;

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic              clear_dirty;

  logic [ENT_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [WAY_W-1:0]  age      [SETS][WAYS];

  logic              hit;
  logic [WAY_W-1:0]  hit_way, inv_way, lru_way, sel_way;
  logic              inv_found;
  logic [WAY_W-1:0]  old_age;
  logic              busy, access, do_write, do_touch;

  logic [IDX_W-1:0]  ptr_set;
  logic [WAY_W-1:0]  ptr_way;
  logic [ENT_W-1:0]  scan_ent;
  logic              ptr_last;

  // Lookup: lowest-index hit wins; otherwise lowest invalid way, else oldest way
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && tag_mem[addr_i][w][VLD_B] &&
          tag_mem[addr_i][w][TAG_W-1:0] == tag_i[TAG_W-1:0]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !tag_mem[addr_i][w][VLD_B]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age[addr_i][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    sel_way = hit ? hit_way : (inv_found ? inv_way : lru_way);
  end

  assign busy     = (state != IDLE);
  assign access   = enable_i && !busy;
  assign do_write = access && write_i;
  assign do_touch = access && (hit || write_i);
  assign old_age  = age[addr_i][sel_way];

  assign hit_o     = hit && !busy;
  assign hit_way_o = sel_way;
  assign tag_o     = tag_mem[addr_i][sel_way];
  assign data_o    = data_mem[addr_i][sel_way];

  assign ptr_set  = ptr[PTR_W-1:WAY_W];
  assign ptr_way  = ptr[WAY_W-1:0];
  assign scan_ent = tag_mem[ptr_set][ptr_way];
  assign ptr_last = (ptr == '1);

  assign flush_busy_o  = busy;
  assign flush_valid_o = (state == OFFER);
  assign flush_done_o  = (state == DONE);
  assign flush_tag_o   = scan_ent[TAG_W-1:0];
  assign flush_idx_o   = ptr_set;
  assign flush_data_o  = data_mem[ptr_set][ptr_way];

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    clear_dirty = 1'b0;
    case (state)
      IDLE: begin
        if (flush_i) begin
          state_nxt = SCAN;
          ptr_nxt   = '0;
        end
      end
      SCAN: begin
        if (scan_ent[VLD_B] && scan_ent[DRT_B]) state_nxt = OFFER;
        else if (ptr_last)                      state_nxt = DONE;
        else                                    ptr_nxt   = ptr + 1'b1;
      end
      OFFER: begin
        if (flush_ready_i) begin
          clear_dirty = 1'b1;
          if (ptr_last) begin
            state_nxt = DONE;
          end else begin
            state_nxt = SCAN;
            ptr_nxt   = ptr + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Array and LRU state; writes happen only when idle, dirty clears only in OFFER
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
          age[s][w]      <= WAY_W'(w);
        end
      end
    end else begin
      if (do_write) begin
        tag_mem[addr_i][sel_way]  <= tag_i;
        data_mem[addr_i][sel_way] <= data_i;
      end
      if (clear_dirty) tag_mem[ptr_set][ptr_way][DRT_B] <= 1'b0;
      if (do_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way)        age[addr_i][w] <= '0;
          else if (age[addr_i][w] < old_age) age[addr_i][w] <= age[addr_i][w] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Self-checking bench for dcache_sram_nway: directed scenarios plus randomized
// traffic checked against a recency-list cache model.
module tb_dcache_sram_nway;

  localparam int WAYS = 4, SETS = 16, IDX_W = 4, TAG_W = 23, DW = 256;

  logic              clk, rst_n;
  logic [IDX_W-1:0]  addr;
  logic [TAG_W+1:0]  tag_in;
  logic [DW-1:0]     data_in;
  logic              en, wr;
  logic [TAG_W+1:0]  tag_out;
  logic [DW-1:0]     data_out;
  logic              hit;
  logic [1:0]        hit_way;
  logic              flush, busy, fvalid, fready, fdone;
  logic [TAG_W-1:0]  ftag;
  logic [IDX_W-1:0]  fidx;
  logic [DW-1:0]     fdata;

  dcache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .tag_i(tag_in), .data_i(data_in),
    .enable_i(en), .write_i(wr), .tag_o(tag_out), .data_o(data_out), .hit_o(hit),
    .hit_way_o(hit_way), .flush_i(flush), .flush_busy_o(busy), .flush_valid_o(fvalid),
    .flush_ready_i(fready), .flush_tag_o(ftag), .flush_idx_o(fidx), .flush_data_o(fdata),
    .flush_done_o(fdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: per-set recency list, position 0 = most recently used
  logic [TAG_W+1:0] mtag  [SETS][WAYS];
  logic [DW-1:0]    mdata [SETS][WAYS];
  int               mord  [SETS][WAYS];

  task automatic mreset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        mtag[s][w] = '0; mdata[s][w] = '0; mord[s][w] = w;
      end
  endtask

  task automatic mlook(input int s, input logic [TAG_W-1:0] t, output bit h, output int way);
    h = 0; way = -1;
    for (int w = 0; w < WAYS; w++)
      if (!h && mtag[s][w][TAG_W+1] && mtag[s][w][TAG_W-1:0] == t) begin h = 1; way = w; end
    if (!h) begin
      for (int w = 0; w < WAYS; w++) if (way < 0 && !mtag[s][w][TAG_W+1]) way = w;
      if (way < 0) way = mord[s][WAYS-1];
    end
  endtask

  task automatic mtouch(input int s, input int way);
    int p = 0;
    for (int k = 0; k < WAYS; k++) if (mord[s][k] == way) p = k;
    for (int k = p; k > 0; k--) mord[s][k] = mord[s][k-1];
    mord[s][0] = way;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input int s, input logic [TAG_W+1:0] t, input logic [DW-1:0] d,
                        input bit e, input bit w);
    addr = IDX_W'(s); tag_in = t; data_in = d; en = e; wr = w;
    #2;
  endtask

  // Applies the current (idle-time) access to the model, then clocks it in
  task automatic commit();
    bit h; int way;
    if (en) begin
      mlook(int'(addr), tag_in[TAG_W-1:0], h, way);
      if (wr) begin mtag[addr][way] = tag_in; mdata[addr][way] = data_in; end
      if (h || wr) mtouch(int'(addr), way);
    end
    tick();
    en = 0; wr = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; wr = 0; flush = 0; fready = 0;
    addr = '0; tag_in = '0; data_in = '0;
    tick(); tick();
    rst_n = 1;
    tick();
    mreset();
  endtask

  task automatic test_reset();
    do_reset();
    set_in(3, {2'b10, 23'h1234}, '0, 0, 0);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got %0d want 0", hit); end
    n_cmp++; if (hit_way !== 2'd0) begin n_err++; $display("FAIL reset_way got %0d want 0", hit_way); end
    n_cmp++; if (tag_out !== '0) begin n_err++; $display("FAIL reset_tag got %h want 0", tag_out); end
    n_cmp++; if ({busy, fvalid, fdone} !== 3'b000) begin n_err++; $display("FAIL reset_flush_outs got %b want 000", {busy, fvalid, fdone}); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_in(5, {2'b10, 23'(32'hA + i)}, rnd_line(), 1, 1);
      commit();
    end
    for (int i = 0; i < 4; i++) begin
      set_in(5, {2'b10, 23'(32'hA + i)}, '0, 1, 0);
      n_cmp++; if (hit !== 1'b1) begin n_err++; $display("FAIL fill_hit%0d got %0d want 1", i, hit); end
      n_cmp++; if (hit_way !== 2'(i)) begin n_err++; $display("FAIL fill_way%0d got %0d want %0d", i, hit_way, i); end
      n_cmp++; if (data_out !== mdata[5][i]) begin n_err++; $display("FAIL fill_data%0d got %h want %h", i, data_out, mdata[5][i]); end
      commit();
    end
  endtask

  task automatic test_lru();
    bit h; int way;
    logic [22:0] rd [3];
    rd[0] = 23'hA; rd[1] = 23'hC; rd[2] = 23'hD;
    for (int i = 0; i < 3; i++) begin
      set_in(5, {2'b10, rd[i]}, '0, 1, 0);
      commit();
    end
    set_in(5, {2'b10, 23'hE}, rnd_line(), 1, 1);
    n_cmp++; if ({hit, hit_way} !== {1'b0, 2'd1}) begin n_err++; $display("FAIL lru_victim got hit=%0d way=%0d want hit=0 way=1", hit, hit_way); end
    commit();
    set_in(5, {2'b10, 23'hE}, '0, 1, 0);
    n_cmp++; if ({hit, hit_way} !== {1'b1, 2'd1}) begin n_err++; $display("FAIL lru_e_way got hit=%0d way=%0d want hit=1 way=1", hit, hit_way); end
    commit();
    set_in(5, {2'b10, 23'hB}, '0, 1, 0);
    mlook(5, 23'hB, h, way);
    n_cmp++; if ({hit, hit_way} !== {h, 2'(way)}) begin n_err++; $display("FAIL lru_b_miss got hit=%0d way=%0d want hit=%0d way=%0d", hit, hit_way, h, way); end
    commit();
  endtask

  task automatic test_flush_handshake();
    int n; int dones;
    logic [DW-1:0] d21, d93;
    do_reset();
    d21 = rnd_line(); d93 = rnd_line();
    set_in(2, {2'b10, 23'h100}, rnd_line(), 1, 1); commit();
    set_in(2, {2'b11, 23'h101}, d21, 1, 1); commit();
    for (int i = 0; i < 3; i++) begin set_in(9, {2'b10, 23'(32'h200 + i)}, rnd_line(), 1, 1); commit(); end
    set_in(9, {2'b11, 23'h203}, d93, 1, 1); commit();
    flush = 1; tick(); flush = 0;
    n = 0;
    while (!fvalid && n < 200) begin tick(); n++; end
    n_cmp++; if (fvalid !== 1'b1) begin n_err++; $display("FAIL hs_offer1 got valid=%0d want 1 within 200 cycles", fvalid); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({fvalid, fidx, ftag} !== {1'b1, 4'd2, 23'h101}) begin
        n_err++; $display("FAIL hs_hold%0d got valid=%0d idx=%0d tag=%h want 1/2/101", c, fvalid, fidx, ftag); end
      tick();
    end
    n_cmp++; if (fdata !== d21) begin n_err++; $display("FAIL hs_data1 got %h want %h", fdata, d21); end
    fready = 1; tick(); fready = 0;
    mtag[2][1][TAG_W] = 1'b0;
    n = 0;
    while (!fvalid && n < 200) begin tick(); n++; end
    n_cmp++; if ({fvalid, fidx, ftag} !== {1'b1, 4'd9, 23'h203}) begin
      n_err++; $display("FAIL hs_offer2 got valid=%0d idx=%0d tag=%h want 1/9/203", fvalid, fidx, ftag); end
    n_cmp++; if (fdata !== d93) begin n_err++; $display("FAIL hs_data2 got %h want %h", fdata, d93); end
    fready = 1; tick(); fready = 0;
    mtag[9][3][TAG_W] = 1'b0;
    dones = 0;
    for (int c = 0; c < 80; c++) begin if (fdone) dones++; tick(); end
    n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL hs_done_count got %0d want 1", dones); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs_busy_end got %0d want 0", busy); end
    set_in(2, {2'b10, 23'h101}, '0, 1, 0);
    n_cmp++; if ({hit, tag_out} !== {1'b1, 2'b10, 23'h101}) begin n_err++; $display("FAIL hs_clean21 got hit=%0d tag=%h", hit, tag_out); end
    commit();
    set_in(9, {2'b10, 23'h203}, '0, 1, 0);
    n_cmp++; if ({hit, tag_out} !== {1'b1, 2'b10, 23'h203}) begin n_err++; $display("FAIL hs_clean93 got hit=%0d tag=%h", hit, tag_out); end
    commit();
  endtask

  task automatic test_clean_flush();
    int cycles; int offers;
    logic [DW-1:0] d0, d1;
    do_reset();
    d0 = rnd_line(); d1 = rnd_line();
    set_in(0, {2'b10, 23'h55}, d0, 1, 1); commit();
    set_in(1, {2'b10, 23'h77}, d1, 1, 1);
    flush = 1;
    commit();
    flush = 0;
    cycles = 1; offers = 0;
    while (!fdone && cycles < 200) begin
      if (cycles == 3) begin addr = 4'd0; tag_in = {2'b11, 23'h66}; data_in = rnd_line(); en = 1; wr = 1; end
      if (fvalid) offers++;
      tick();
      en = 0; wr = 0;
      cycles++;
    end
    n_cmp++; if (cycles !== 65) begin n_err++; $display("FAIL clean_done_latency got %0d want 65", cycles); end
    n_cmp++; if (offers !== 0) begin n_err++; $display("FAIL clean_offers got %0d want 0", offers); end
    tick();
    set_in(0, {2'b10, 23'h55}, '0, 1, 0);
    n_cmp++; if ({hit, data_out} !== {1'b1, d0}) begin n_err++; $display("FAIL clean_set0_kept got hit=%0d data=%h", hit, data_out); end
    commit();
    set_in(0, {2'b10, 23'h66}, '0, 1, 0);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL clean_busy_write got hit=%0d want 0", hit); end
    commit();
    set_in(1, {2'b10, 23'h77}, '0, 1, 0);
    n_cmp++; if ({hit, data_out} !== {1'b1, d1}) begin n_err++; $display("FAIL clean_same_cycle_write got hit=%0d data=%h", hit, data_out); end
    commit();
  endtask

  task automatic test_reset_in_offer();
    int n; int dones;
    do_reset();
    set_in(4, {2'b11, 23'h4321}, rnd_line(), 1, 1); commit();
    flush = 1; tick(); flush = 0;
    n = 0;
    while (!fvalid && n < 200) begin tick(); n++; end
    n_cmp++; if (fvalid !== 1'b1) begin n_err++; $display("FAIL rst_offer_reached got %0d want 1", fvalid); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({fvalid, busy, fdone} !== 3'b000) begin n_err++; $display("FAIL rst_async_drop got %b want 000", {fvalid, busy, fdone}); end
    tick();
    rst_n = 1;
    mreset();
    dones = 0;
    for (int c = 0; c < 80; c++) begin if (fdone) dones++; tick(); end
    n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rst_no_done got %0d want 0", dones); end
    set_in(4, {2'b10, 23'h4321}, '0, 1, 0);
    n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL rst_miss got %0d want 0", hit); end
    commit();
  endtask

  task automatic test_random_traffic();
    bit h; int way; int s;
    logic [TAG_W+1:0] t;
    for (int i = 0; i < 300; i++) begin
      s = $urandom_range(0, 3);
      t = {($urandom_range(0, 7) != 0), 1'($urandom), 23'($urandom_range(1, 6))};
      set_in(s, t, rnd_line(), ($urandom_range(0, 3) != 0), 1'($urandom));
      mlook(s, t[TAG_W-1:0], h, way);
      n_cmp++; if ({hit, hit_way} !== {h, 2'(way)}) begin n_err++; $display("FAIL rnd_lookup%0d got hit=%0d way=%0d want hit=%0d way=%0d", i, hit, hit_way, h, way); end
      n_cmp++; if ({tag_out, data_out} !== {mtag[s][way], mdata[s][way]}) begin n_err++; $display("FAIL rnd_entry%0d got tag=%h want tag=%h", i, tag_out, mtag[s][way]); end
      commit();
    end
  endtask

  task automatic test_random_flush();
    int exp_q[$]; int n; int e; bit got_done;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (mtag[s][w][TAG_W+1] && mtag[s][w][TAG_W]) exp_q.push_back(s * WAYS + w);
    flush = 1; tick(); flush = 0;
    n = 0; got_done = 0;
    while (!got_done && n < 3000) begin
      if (fdone) got_done = 1;
      else if (fvalid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL rflush_extra_offer got idx=%0d tag=%h want none", fidx, ftag);
        end else begin
          e = exp_q[0];
          n_cmp++; if ({fidx, ftag, fdata} !== {4'(e / WAYS), mtag[e/WAYS][e%WAYS][TAG_W-1:0], mdata[e/WAYS][e%WAYS]}) begin
            n_err++; $display("FAIL rflush_offer got idx=%0d tag=%h want idx=%0d tag=%h", fidx, ftag, e / WAYS, mtag[e/WAYS][e%WAYS][TAG_W-1:0]); end
          fready = 1'($urandom);
          if (fready) begin mtag[e/WAYS][e%WAYS][TAG_W] = 1'b0; void'(exp_q.pop_front()); end
        end
      end
      tick();
      fready = 0;
      n++;
    end
    n_cmp++; if (got_done !== 1'b1) begin n_err++; $display("FAIL rflush_done got %0d want 1 within 3000 cycles", got_done); end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rflush_left got %0d offers pending want 0", exp_q.size()); end
    tick();
    test_random_traffic();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lru();
    test_flush_handshake();
    test_clean_flush();
    test_reset_in_offer();
    test_random_traffic();
    test_random_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
